// File: rtl/rf_writeback.sv
// Register-file write-port initiator: arbitrates load returns, ALU results and RIM immediates.
// Optional `RF_WB_OUTREG_EN registers the write port (1-cycle latency); default drives it combinationally.

module rf_wb_pend #(
  parameter int CW = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_busy
);
  logic [CW-1:0] r_cnt;

  // Simultaneous inc/dec leaves the count untouched so busy never glitches low.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                r_cnt <= '0;
    else if (i_inc && !i_dec)  r_cnt <= r_cnt + CW'(1);
    else if (i_dec && !i_inc)  r_cnt <= r_cnt - CW'(1);
  end

  assign o_busy = (r_cnt != '0);
endmodule

module rf_writeback #(
  parameter int W        = 8,
  parameter int D        = 3,
  parameter int LQ_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              alu_valid,
  input  logic [D-1:0]      alu_waddr,
  input  logic [W-1:0]      alu_data,
  output logic              alu_ready,
  input  logic              imm_valid,
  input  logic [W-1:0]      imm_data,
  output logic              imm_ready,
  input  logic              ld_issue,
  input  logic [D-1:0]      ld_waddr,
  output logic              ld_issue_ready,
  input  logic              ld_valid,
  input  logic [W-1:0]      ld_data,
  output logic              ld_ready,
  output logic [(1<<D)-1:0] busy,
  output logic              write_en,
  output logic              write_imm,
  output logic [D-1:0]      waddr,
  output logic [W-1:0]      data_in,
  output logic [W-1:0]      imm_in
);
  localparam int NR = 1 << D;
  localparam int CW = $clog2(LQ_DEPTH + 1);
  localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;

  typedef struct packed {
    logic         en;
    logic         imm;
    logic [D-1:0] addr;
    logic [W-1:0] data;
    logic [W-1:0] imm_data;
  } wr_t;

  logic [D-1:0]  r_tag [LQ_DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;

  logic          w_nonempty, w_push, w_pop, w_alu_fire, w_imm_fire;
  logic [D-1:0]  w_head_tag;
  logic [NR-1:0] w_busy;
  wr_t           w_wr, w_out;

  assign w_nonempty     = (r_count != '0);
  assign w_head_tag     = r_tag[r_head];

  assign imm_ready      = RST_N;
  assign ld_issue_ready = RST_N && (r_count < CW'(LQ_DEPTH));
  assign ld_ready       = RST_N && ld_valid && w_nonempty;
  assign alu_ready      = RST_N && !(ld_valid && w_nonempty) && !w_busy[alu_waddr];

  assign w_push     = ld_issue && ld_issue_ready;
  assign w_pop      = ld_ready;
  assign w_alu_fire = alu_valid && alu_ready;
  assign w_imm_fire = imm_valid && imm_ready;

  // Tag queue: circular FIFO, pointers wrap at LQ_DEPTH (not necessarily a power of two).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= (r_tail == PW'(LQ_DEPTH - 1)) ? '0 : r_tail + PW'(1);
      if (w_pop)  r_head <= (r_head == PW'(LQ_DEPTH - 1)) ? '0 : r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_tag[r_tail] <= ld_waddr;
  end

  // Per-register pending counters; r0 never reports busy since its writes are discarded.
  for (genvar r = 0; r < NR; r++) begin : g_pend
    if (r == 0) begin : g_r0
      assign w_busy[r] = 1'b0;
    end else begin : g_rn
      rf_wb_pend #(.CW(CW)) u_pend (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .i_inc  (w_push && (ld_waddr == D'(r))),
        .i_dec  (w_pop && (w_head_tag == D'(r))),
        .o_busy (w_busy[r])
      );
    end
  end

  assign busy = w_busy;

  always_comb begin
    w_wr = '0;
    if (w_pop) begin
      w_wr.en   = 1'b1;
      w_wr.addr = w_head_tag;
      w_wr.data = ld_data;
    end else if (w_alu_fire) begin
      w_wr.en   = 1'b1;
      w_wr.addr = alu_waddr;
      w_wr.data = alu_data;
    end
    if (w_imm_fire) begin
      w_wr.en       = 1'b1;
      w_wr.imm      = 1'b1;
      w_wr.imm_data = imm_data;
    end
  end

`ifdef RF_WB_OUTREG_EN
  wr_t r_wr;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_wr <= '0;
    else        r_wr <= w_wr;
  end
  assign w_out = r_wr;
`else
  // All fire terms are gated by RST_N, so this is already 0 in reset.
  assign w_out = w_wr;
`endif

  assign write_en  = w_out.en;
  assign write_imm = w_out.imm;
  assign waddr     = w_out.addr;
  assign data_in   = w_out.data;
  assign imm_in    = w_out.imm_data;
endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: queue/scan model checked every cycle plus literal write-log checks.
module tb_rf_writeback;
  localparam int W = 8, D = 3, LQ_DEPTH = 2;
`ifdef RF_WB_OUTREG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic CLK = 0, RST_N = 0;
  logic alu_valid = 0, imm_valid = 0, ld_issue = 0, ld_valid = 0;
  logic [D-1:0] alu_waddr = 0, ld_waddr = 0;
  logic [W-1:0] alu_data = 0, imm_data = 0, ld_data = 0;
  logic alu_ready, imm_ready, ld_issue_ready, ld_ready;
  logic [7:0] busy;
  logic write_en, write_imm;
  logic [D-1:0] waddr;
  logic [W-1:0] data_in, imm_in;

  rf_writeback #(.W(W), .D(D), .LQ_DEPTH(LQ_DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_data(alu_data), .alu_ready(alu_ready),
    .imm_valid(imm_valid), .imm_data(imm_data), .imm_ready(imm_ready),
    .ld_issue(ld_issue), .ld_waddr(ld_waddr), .ld_issue_ready(ld_issue_ready),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .busy(busy), .write_en(write_en), .write_imm(write_imm), .waddr(waddr),
    .data_in(data_in), .imm_in(imm_in)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: list of pending load tags; busy derived by scanning it.
  logic [D-1:0] mq[$];
  logic [19:0]  wlog[$];
  logic         m_pop, m_push;
  logic [D-1:0] m_push_tag;
  logic [20:0]  cur, prev;   // {en, imm, addr, data, imm_in}

  initial begin m_pop = 0; m_push = 0; m_push_tag = 0; cur = 0; prev = 0; end

  always @(negedge CLK) begin
    logic [7:0] e_busy;
    logic e_ldr, e_alur, e_issr, ne;
    logic [20:0] e_out;
    e_busy = 0; e_ldr = 0; e_alur = 0; e_issr = 0; cur = 0;
    m_pop = 0; m_push = 0;
    if (!RST_N) begin
      mq.delete();
      prev = 0;
    end else begin
      ne = (mq.size() != 0);
      foreach (mq[i]) if (mq[i] != 0) e_busy[mq[i]] = 1'b1;
      e_ldr  = ld_valid && ne;
      e_alur = !(ld_valid && ne) && !e_busy[alu_waddr];
      e_issr = (mq.size() < LQ_DEPTH);
      m_pop  = e_ldr;
      m_push = ld_issue && e_issr;
      m_push_tag = ld_waddr;
      if (m_pop)                    cur = {1'b1, 1'b0, mq[0], ld_data, 8'h00};
      else if (alu_valid && e_alur) cur = {1'b1, 1'b0, alu_waddr, alu_data, 8'h00};
      if (imm_valid) begin cur[20] = 1'b1; cur[19] = 1'b1; cur[7:0] = imm_data; end
    end
    e_out = (LAT == 0) ? cur : prev;
    chk("imm_ready", imm_ready, RST_N);
    chk("ld_ready", ld_ready, e_ldr);
    chk("alu_ready", alu_ready, e_alur);
    chk("ld_issue_ready", ld_issue_ready, e_issr);
    chk("busy", busy, e_busy);
    chk("write_en", write_en, e_out[20]);
    chk("write_imm", write_imm, e_out[19]);
    chk("waddr", waddr, e_out[18:16]);
    chk("data_in", data_in, e_out[15:8]);
    chk("imm_in", imm_in, e_out[7:0]);
    if (write_en) wlog.push_back({write_imm, waddr, data_in, imm_in});
  end

  always @(posedge CLK) begin
    if (RST_N) begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(m_push_tag);
      prev = cur;
    end else begin
      mq.delete();
      prev = 0;
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic log_expect(input logic imm, input logic [D-1:0] a, input logic [W-1:0] d,
                            input logic [W-1:0] im);
    if (wlog.size() == 0) chk("log_entry_present", 0, 1);
    else chk("log_write", wlog.pop_front(), {imm, a, d, im});
  endtask

  task automatic log_empty();
    chk("log_empty", wlog.size(), 0);
    wlog.delete();
  endtask

  initial begin
    // Reset with valids high
    ld_valid = 1; alu_valid = 1; alu_waddr = 3;
    tick(); @(negedge CLK);
    chk("rst_readies", {alu_ready, imm_ready, ld_issue_ready, ld_ready}, 4'b0000);
    chk("rst_busy", busy, 8'h00);
    chk("rst_write_en", write_en, 0);
    tick(); RST_N = 1; ld_valid = 0; alu_valid = 0;
    tick();
    log_empty();

    // ALU r3 = 0x5A
    alu_valid = 1; alu_waddr = 3; alu_data = 8'h5A;
    tick(); alu_valid = 0; tick(); tick();
    log_expect(0, 3, 8'h5A, 8'h00); log_empty();

    // Imm alone, then imm + ALU r2
    imm_valid = 1; imm_data = 8'h7F; tick();
    imm_data = 8'h11; alu_valid = 1; alu_waddr = 2; alu_data = 8'h22; tick();
    imm_valid = 0; alu_valid = 0; tick(); tick();
    log_expect(1, 0, 8'h00, 8'h7F); log_expect(1, 2, 8'h22, 8'h11); log_empty();

    // WAW stall behind load r5
    ld_issue = 1; ld_waddr = 5; tick(); ld_issue = 0;
    alu_valid = 1; alu_waddr = 5; alu_data = 8'h01;
    @(negedge CLK); chk("waw_alu_ready", alu_ready, 0); chk("waw_busy5", busy[5], 1);
    tick(); ld_valid = 1; ld_data = 8'hAB;
    @(negedge CLK); chk("waw_ld_ready", ld_ready, 1);
    tick(); ld_valid = 0;
    @(negedge CLK); chk("waw_alu_ready_after", alu_ready, 1); chk("waw_busy5_clr", busy[5], 0);
    tick(); alu_valid = 0; tick(); tick();
    log_expect(0, 5, 8'hAB, 8'h00); log_expect(0, 5, 8'h01, 8'h00); log_empty();

    // Depth 2: r1, r1, r4 blocked
    ld_issue = 1; ld_waddr = 1; tick(); tick();
    ld_waddr = 4;
    @(negedge CLK); chk("full_issue_ready", ld_issue_ready, 0);
    tick(); ld_issue = 0; ld_valid = 1; ld_data = 8'h10;
    tick(); ld_data = 8'h20;
    @(negedge CLK); chk("busy1_held", busy[1], 1); chk("busy4_never", busy[4], 0);
    tick(); ld_valid = 0;
    @(negedge CLK); chk("busy1_clr", busy[1], 0);
    tick(); tick();
    log_expect(0, 1, 8'h10, 8'h00); log_expect(0, 1, 8'h20, 8'h00); log_empty();

    // Push and pop to the same register in one cycle
    ld_issue = 1; ld_waddr = 1; tick();
    ld_valid = 1; ld_data = 8'h30; tick();
    ld_issue = 0; ld_data = 8'h40;
    @(negedge CLK); chk("pushpop_busy1", busy[1], 1);
    tick(); ld_valid = 0;
    @(negedge CLK); chk("pushpop_busy1_clr", busy[1], 0);
    tick(); tick();
    log_expect(0, 1, 8'h30, 8'h00); log_expect(0, 1, 8'h40, 8'h00); log_empty();

    // Load return beats ALU r6; then ld_valid on empty queue
    ld_issue = 1; ld_waddr = 3; tick(); ld_issue = 0;
    ld_valid = 1; ld_data = 8'h55; alu_valid = 1; alu_waddr = 6; alu_data = 8'h66;
    @(negedge CLK); chk("arb_alu_ready", alu_ready, 0);
    tick(); ld_valid = 0;
    @(negedge CLK); chk("arb_alu_ready_next", alu_ready, 1);
    tick(); alu_valid = 0; ld_valid = 1; ld_data = 8'hEE;
    @(negedge CLK); chk("empty_ld_ready", ld_ready, 0);
    tick(); ld_valid = 0; tick(); tick();
    log_expect(0, 3, 8'h55, 8'h00); log_expect(0, 6, 8'h66, 8'h00); log_empty();

    // Load to r0: queued and written, never busy
    ld_issue = 1; ld_waddr = 0; tick(); ld_issue = 0;
    @(negedge CLK); chk("r0_busy", busy, 8'h00);
    tick(); ld_valid = 1; ld_data = 8'h77; tick(); ld_valid = 0; tick(); tick();
    log_expect(0, 0, 8'h77, 8'h00); log_empty();

    // Reset with two loads pending
    ld_issue = 1; ld_waddr = 2; tick(); ld_waddr = 7; tick(); ld_issue = 0;
    @(negedge CLK); chk("pend_busy", busy, 8'h84);
    tick(); RST_N = 0;
    @(negedge CLK); chk("rst2_busy", busy, 8'h00);
    chk("rst2_readies", {alu_ready, imm_ready, ld_issue_ready, ld_ready}, 4'b0000);
    tick(); RST_N = 1; ld_valid = 1; ld_data = 8'h99;
    @(negedge CLK); chk("post_rst_ld_ready", ld_ready, 0);
    tick(); ld_valid = 0; tick(); tick();
    log_empty();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
